// File: rtl/apb_pkg.sv
// ============================================================================
// apb_pkg : shared types and default widths for the APB requester
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

  localparam int c_APB_ADDR_W = 11;
  localparam int c_APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_e;

  typedef struct packed {
    logic [c_APB_ADDR_W-1:0]   addr;
    logic                      write;
    logic [c_APB_DATA_W/8-1:0] strb;
    logic [c_APB_DATA_W-1:0]   wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [c_APB_DATA_W-1:0] rdata;
    logic                    slverr;
    logic                    timeout;
  } apb_rsp_t;

endpackage

`default_nettype wire

// File: rtl/apb_req_watchdog.sv
// ============================================================================
// apb_req_watchdog : saturating pready wait counter; expires on the last
// permitted ACCESS cycle. TIMEOUT_CYCLES=0 disables expiry entirely.
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_req_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
      localparam logic [CNT_W-1:0] c_SAT   = CNT_W'(TIMEOUT_CYCLES);

      logic [CNT_W-1:0] r_count;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_count <= '0;
        end else if (i_clear) begin
          r_count <= '0;
        end else if (i_enable && (r_count != c_SAT)) begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      assign o_expire = (r_count == c_LIMIT);
    end else begin : g_no_wd
      assign o_expire = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_requester.sv
// ============================================================================
// apb_requester : valid/ready command port to APB4 SETUP/ACCESS transfers,
// with registered APB outputs, a held response port and a pready watchdog.
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_W         = c_APB_ADDR_W,
  parameter int DATA_W         = c_APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic                cmd_write,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_slverr,
  output logic                rsp_timeout,
  output logic                busy,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic                psel,
  output logic                penable,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;

  apb_req_state_e      r_state,      w_state_nxt;
  logic [ADDR_W-1:0]   r_paddr,      w_paddr_nxt;
  logic                r_pwrite,     w_pwrite_nxt;
  logic                r_psel,       w_psel_nxt;
  logic                r_penable,    w_penable_nxt;
  logic [STRB_W-1:0]   r_pstrb,      w_pstrb_nxt;
  logic [DATA_W-1:0]   r_pwdata,     w_pwdata_nxt;
  logic                r_rsp_valid,  w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata,  w_rsp_rdata_nxt;
  logic                r_rsp_slverr, w_rsp_slverr_nxt;
  logic                r_rsp_tmo,    w_rsp_tmo_nxt;

  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expire;

  apb_req_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expire (w_wd_expire)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_paddr_nxt      = r_paddr;
    w_pwrite_nxt     = r_pwrite;
    w_psel_nxt       = r_psel;
    w_penable_nxt    = r_penable;
    w_pstrb_nxt      = r_pstrb;
    w_pwdata_nxt     = r_pwdata;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    w_rsp_slverr_nxt = r_rsp_slverr;
    w_rsp_tmo_nxt    = r_rsp_tmo;
    w_wd_clear       = 1'b0;
    w_wd_enable      = 1'b0;

    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_paddr_nxt   = cmd_addr;
          w_pwrite_nxt  = cmd_write;
          w_pwdata_nxt  = cmd_wdata;
          w_pstrb_nxt   = cmd_write ? cmd_strb : '0;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = SETUP;
        end
      end

      SETUP: begin
        w_penable_nxt = 1'b1;
        w_wd_clear    = 1'b1;
        w_state_nxt   = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          w_rsp_rdata_nxt  = r_pwrite ? '0 : prdata;
          w_rsp_slverr_nxt = pslverr;
          w_rsp_tmo_nxt    = 1'b0;
          w_psel_nxt       = 1'b0;
          w_penable_nxt    = 1'b0;
          w_rsp_valid_nxt  = 1'b1;
          w_state_nxt      = RESP;
        end else begin
          w_wd_enable = 1'b1;
          // Expiry is sampled on the current count, so the abort lands on
          // the last permitted ACCESS cycle rather than one later.
          if (w_wd_expire) begin
            w_psel_nxt       = 1'b0;
            w_penable_nxt    = 1'b0;
            w_rsp_slverr_nxt = 1'b1;
            w_rsp_tmo_nxt    = 1'b1;
            w_rsp_rdata_nxt  = '0;
            w_rsp_valid_nxt  = 1'b1;
            w_state_nxt      = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pstrb      <= '0;
      r_pwdata     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
      r_rsp_tmo    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_paddr      <= w_paddr_nxt;
      r_pwrite     <= w_pwrite_nxt;
      r_psel       <= w_psel_nxt;
      r_penable    <= w_penable_nxt;
      r_pstrb      <= w_pstrb_nxt;
      r_pwdata     <= w_pwdata_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
      r_rsp_slverr <= w_rsp_slverr_nxt;
      r_rsp_tmo    <= w_rsp_tmo_nxt;
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pstrb       = r_pstrb;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_tmo;

endmodule

`default_nettype wire

// File: tb/tb_apb_requester.sv
// ============================================================================
// tb_apb_requester : directed transactions against a transaction-level model
// of the requester, with a programmable-wait APB completer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_requester;
  import apb_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [10:0] cmd_addr;
  logic [3:0]  cmd_strb;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [10:0] paddr;
  logic        pwrite, psel, penable;
  logic [3:0]  pstrb;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  apb_requester #(.ADDR_W(11), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_strb(cmd_strb), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .busy(busy),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model expectations for the transaction currently in flight
  logic [10:0] exp_addr;
  logic        exp_write;
  logic [3:0]  exp_strb;
  logic [31:0] exp_wdata, exp_rdata;
  logic        exp_slverr, exp_timeout;
  int          exp_psel_cyc, exp_pen_cyc;

  // Completer configuration for the transaction currently in flight
  int          cfg_waits = 0;
  logic [31:0] cfg_prdata = '0;
  logic        cfg_slv = 1'b0;

  int last_psel_cyc = 0;
  int last_pen_cyc  = 0;

  // Completer: pready after cfg_waits wait states; junk on prdata/pslverr otherwise
  int acc_cnt = 0;
  always @(negedge clk) begin
    if (psel && penable) begin
      if (acc_cnt == cfg_waits) begin
        pready = 1'b1; prdata = cfg_prdata; pslverr = cfg_slv;
      end else begin
        pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
      end
      acc_cnt++;
    end else begin
      pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b1; acc_cnt = 0;
    end
  end

  // Per-cycle comparison against the transaction model
  int  psel_cyc = 0, pen_cyc = 0;
  bit  rsp_seen = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      psel_cyc = 0; pen_cyc = 0; rsp_seen = 0;
    end else begin
      chk("cmd_ready_idle", cmd_ready, !busy);
      if (!busy) begin
        psel_cyc = 0; pen_cyc = 0; rsp_seen = 0;
      end
      if (psel) begin
        chk("paddr",  paddr,  exp_addr);
        chk("pwrite", pwrite, exp_write);
        chk("pstrb",  pstrb,  exp_strb);
        chk("pwdata", pwdata, exp_wdata);
        psel_cyc++;
        if (penable) pen_cyc++;
      end else begin
        chk("penable_without_psel", penable, 1'b0);
      end
      if (rsp_valid) begin
        chk("rsp_rdata",   rsp_rdata,   exp_rdata);
        chk("rsp_slverr",  rsp_slverr,  exp_slverr);
        chk("rsp_timeout", rsp_timeout, exp_timeout);
        if (!rsp_seen) begin
          chk("psel_cycles",    psel_cyc, exp_psel_cyc);
          chk("penable_cycles", pen_cyc,  exp_pen_cyc);
          last_psel_cyc = psel_cyc;
          last_pen_cyc  = pen_cyc;
          rsp_seen = 1;
        end
      end
    end
  end

  // Present a command; on the accepting edge load the model and completer.
  task automatic issue(input apb_cmd_t c, input int waits, input logic [31:0] prd,
                       input logic slv, output int lat);
    bit to;
    cmd_addr = c.addr; cmd_write = c.write; cmd_strb = c.strb; cmd_wdata = c.wdata;
    cmd_valid = 1'b1;
    lat = 0;
    while (!cmd_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("cmd_accepted", cmd_ready, 1'b1);
    to           = (waits >= TO);
    exp_addr     = c.addr;
    exp_write    = c.write;
    exp_strb     = c.write ? c.strb : 4'h0;
    exp_wdata    = c.wdata;
    exp_timeout  = to;
    exp_slverr   = to ? 1'b1 : slv;
    exp_rdata    = (c.write || to) ? 32'h0 : prd;
    exp_pen_cyc  = to ? TO : waits + 1;
    exp_psel_cyc = exp_pen_cyc + 1;
    cfg_waits = waits; cfg_prdata = prd; cfg_slv = slv;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input int hold, output logic [31:0] rd, output logic se,
                         output logic tmo);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_arrives", rsp_valid, 1'b1);
    rd = rsp_rdata; se = rsp_slverr; tmo = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_no_setup",  psel,      1'b0);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    apb_cmd_t    c;
    int          lat, n;
    logic [31:0] rd;
    logic        se, tmo;

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_addr = '0; cmd_write = 1'b0; cmd_strb = '0; cmd_wdata = '0;
    exp_addr = '0; exp_write = 1'b0; exp_strb = '0; exp_wdata = '0;
    exp_rdata = '0; exp_slverr = 1'b0; exp_timeout = 1'b0;
    exp_psel_cyc = 0; exp_pen_cyc = 0;
    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 11'h0);
    chk("rst_pstrb", pstrb, 4'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_slverr", rsp_slverr, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait write
    c = '{addr: 11'h010, write: 1'b1, strb: 4'hF, wdata: 32'hA5A5_0001};
    issue(c, 0, 32'h0, 1'b0, lat);
    respond(0, rd, se, tmo);
    chk("t1_rdata", rd, 32'h0);
    chk("t1_slverr", se, 1'b0);
    chk("t1_psel_cycles", last_psel_cyc, 2);
    chk("t1_pen_cycles", last_pen_cyc, 1);

    // Read with three wait states; strobes must be suppressed
    c = '{addr: 11'h004, write: 1'b0, strb: 4'hF, wdata: 32'h7777_0000};
    issue(c, 3, 32'h1234_5678, 1'b0, lat);
    respond(0, rd, se, tmo);
    chk("t2_rdata", rd, 32'h1234_5678);
    chk("t2_slverr", se, 1'b0);
    chk("t2_addr_cycles", last_psel_cyc, 5);

    // Write completing with pslverr
    c = '{addr: 11'h020, write: 1'b1, strb: 4'h3, wdata: 32'h0BAD_F00D};
    issue(c, 1, 32'h0, 1'b1, lat);
    respond(0, rd, se, tmo);
    chk("t3_slverr", se, 1'b1);
    chk("t3_timeout", tmo, 1'b0);

    // pready stuck low -> watchdog abort, then a normal read
    c = '{addr: 11'h030, write: 1'b0, strb: 4'h0, wdata: 32'h0};
    issue(c, 1000, 32'hFFFF_FFFF, 1'b0, lat);
    respond(0, rd, se, tmo);
    chk("t4_rdata", rd, 32'h0);
    chk("t4_slverr", se, 1'b1);
    chk("t4_timeout", tmo, 1'b1);
    chk("t4_pen_cycles", last_pen_cyc, 8);
    chk("t4_psel_cycles", last_psel_cyc, 9);
    c = '{addr: 11'h034, write: 1'b0, strb: 4'h0, wdata: 32'h0};
    issue(c, 0, 32'hCAFE_0001, 1'b0, lat);
    respond(0, rd, se, tmo);
    chk("t4b_rdata", rd, 32'hCAFE_0001);
    chk("t4b_timeout", tmo, 1'b0);

    // Response back-pressure with the next command already waiting
    c = '{addr: 11'h040, write: 1'b1, strb: 4'hC, wdata: 32'h1357_9BDF};
    issue(c, 0, 32'h0, 1'b0, lat);
    cmd_addr = 11'h044; cmd_write = 1'b0; cmd_strb = 4'h5; cmd_wdata = 32'h2468_ACE0;
    cmd_valid = 1'b1;
    respond(10, rd, se, tmo);
    chk("t5_rdata", rd, 32'h0);
    c = '{addr: 11'h044, write: 1'b0, strb: 4'h5, wdata: 32'h2468_ACE0};
    issue(c, 2, 32'h55AA_33CC, 1'b0, lat);
    chk("t5_b2b_accept_latency", lat, 0);
    respond(0, rd, se, tmo);
    chk("t5b_rdata", rd, 32'h55AA_33CC);

    // Reset in the middle of ACCESS
    c = '{addr: 11'h050, write: 1'b0, strb: 4'h0, wdata: 32'h0};
    issue(c, 5, 32'h9999_9999, 1'b0, lat);
    n = 0;
    while (!(psel && penable) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_access", psel && penable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_psel", psel, 1'b0);
    chk("t6_rst_penable", penable, 1'b0);
    chk("t6_rst_rsp_valid", rsp_valid, 1'b0);
    chk("t6_rst_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c = '{addr: 11'h058, write: 1'b0, strb: 4'h0, wdata: 32'h0};
    issue(c, 0, 32'h0F0F_0F0F, 1'b0, lat);
    respond(0, rd, se, tmo);
    chk("t6_after_rst_rdata", rd, 32'h0F0F_0F0F);
    chk("t6_after_rst_slverr", se, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
